ram_rr_arbiter: RTL
===================

Name: ram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous RAM (1-cycle registered read, no read on write cycles) between NUM_REQ requesters.
- Grants at most one access per cycle, drives the RAM port, and routes read data back to the winning requester one cycle later.
- Sits between client engines and the RAM instance. The RAM itself is instantiated outside this block.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width (2^ADDR_WIDTH words).
- NUM_REQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flat; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flat; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; the access is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters; qualified by rsp_valid.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_din  out  DATA_WIDTH  to RAM write data.
- ram_dout  in  DATA_WIDTH  from RAM read data (registered inside the RAM).

Behaviour:
- State held in the block:
  - Round-robin pointer ptr (index of the highest-priority requester).
  - Response register rsp_pend (valid flag + one-hot owner).
- Reset (async, rst=1):
  - ptr=0, rsp_pend cleared, so rsp_valid=0.
  - While rst=1, req_ready=0, ram_we=0, ram_addr=0, ram_din=0.
  - Reset mid-operation drops any pending read response; it is never delivered.
- Grant (combinational, each cycle):
  - Winner w = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready = onehot(w).
  - No valid requester: req_ready=0, ram_we=0, ram_addr=0, ram_din=0.
- RAM drive when a winner exists:
  - ram_addr = req_addr slice w.
  - ram_din = req_wdata slice w.
  - ram_we = req_we[w].
- Pointer update at a clock edge with a grant: ptr <= (w+1) mod NUM_REQ. No grant: ptr holds.
- Read latency:
  - A read accepted in cycle T gives rsp_valid[w]=1 for exactly cycle T+1.
  - In that cycle rsp_rdata = ram_dout (combinational pass-through).
  - Writes produce no response.
- Throughput: one access per cycle, with back-to-back grants allowed. A read in T+1 may overlap the response of a read granted in T.
- Read-after-write to the same address in consecutive cycles returns the newly written data.
- rsp_rdata is don't-care when rsp_valid=0; the bench must not check it then.
- Requesters may change or drop req_valid/fields at any time before acceptance. The arbiter holds no state about un-granted requests.
- A requester that keeps req_valid high is granted at least once every NUM_REQ cycles (no starvation).
- NUM_REQ=1 degenerates to pass-through with ptr constant 0.

Decomposition:
- Shared package ram_arb_pkg:
  - Default DATA_WIDTH/ADDR_WIDTH/NUM_REQ constants.
  - Function onehot_to_idx.
  - Function rr_next(ptr, n).
- Sub-module rr_grant:
  - Combinational rotate-priority-rotate-back logic, inputs req_valid and ptr, outputs one-hot grant and index w.
  - Reusable by other shared-resource controllers.
- The top level holds ptr, rsp_pend and the RAM port muxing.

Test Plan:
1. Reset: assert rst mid-read (read of addr 3 accepted, rst in T+1) -> rsp_valid=0 immediately, ram_we=0, ptr=0; after release a single request from req0 is granted the same cycle.
2. Single requester: req0 writes 0xA5 to addr 5, then reads addr 5 next cycle -> req_ready[0]=1 both cycles; rsp_valid[0]=1 in the cycle after the read with rsp_rdata=0xA5.
3. Contention: req0 and req1 both valid for 4 cycles (all reads, addrs 1 and 2 preloaded 0x11/0x22) -> grants alternate 0,1,0,1; rsp_valid alternates 0,1,0,1 one cycle later with data 0x11,0x22,0x11,0x22.
4. Pointer wrap, NUM_REQ=3: all three valid -> grants 0,1,2,0; drop req1 -> sequence skips 1 (0,2,0,2).
5. Simultaneous write/read: req1 writes 0x3C to addr 7 while req0 reads addr 7 in the same cycle with ptr=1 -> req1 granted first; req0 granted next cycle and receives 0x3C.
6. Idle gaps: no req_valid for 3 cycles -> req_ready=0, ram_we=0, ptr unchanged, no rsp_valid pulses.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the RAM round-robin arbiter.
// Index widths are sized for the largest supported requester count (8).
package ram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_REQ    = 2;
    localparam int MAX_REQ        = 8;
    localparam int IDX_W          = 3;

    // OR-reduction form: with a true one-hot input this is the bit position.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr, input int unsigned n);
        if (32'(ptr) >= n - 1) return '0;
        return ptr + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotating-priority grant.
// Requests are rotated so that ptr sits at bit 0, the lowest set bit wins, and the winner is rotated back.
module rr_grant
    import ram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [N-1:0] rot;
    logic [N-1:0] pri;

    always_comb begin
        rot   = N'({req, req} >> ptr);
        pri   = rot & (~rot + N'(1));
        grant = N'(({pri, pri} << ptr) >> N);
        idx   = IW'(onehot_to_idx(MAX_REQ'(grant)));
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NUM_REQ requesters.
// Read data comes straight from the RAM output register, tagged with the owner captured at grant.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_din,
    input  logic [DATA_WIDTH-1:0]          ram_dout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_owner_q, rsp_owner_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic               any_grant;

    rr_grant #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_grant (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx)
    );

    // The RAM port is forced quiet while reset is held, not only after it.
    always_comb begin
        any_grant   = (|grant) & ~rst;
        req_ready   = rst ? '0 : grant;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        ptr_d       = ptr_q;
        rsp_vld_d   = 1'b0;
        rsp_owner_d = '0;
        if (any_grant) begin
            ram_we      = req_we[win_idx];
            ram_addr    = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ram_din     = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            ptr_d       = IW'(rr_next(IDX_W'(win_idx), NUM_REQ));
            rsp_vld_d   = ~req_we[win_idx];
            rsp_owner_d = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign rsp_valid = rsp_vld_q ? rsp_owner_q : '0;
    assign rsp_rdata = ram_dout;

endmodule
